// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the memory/write-back stage and data memory.
interface mem_wb_stage_if;
  logic        memEn;
  logic        memWrEn;
  logic [0:31] memAddr;
  logic [0:63] dataOut;
  logic [0:63] dataIn;
  logic        mem_ready;

  modport master (
    output memEn, memWrEn, memAddr, dataOut,
    input  dataIn, mem_ready
  );

  modport slave (
    input  memEn, memWrEn, memAddr, dataOut,
    output dataIn, mem_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: performs loads and stores over a ready
// handshake, drives the register-file write-back port, stalls upstream
// while an access is outstanding and abandons accesses that never complete.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting ALU-stage results; ALU ops write back next cycle
// MEM_WAIT | load/store outstanding; bus held, waiting for mem_ready
module mem_wb_stage #(
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [0:1]    alu_op,
  input  logic [0:4]    alu_rD,
  input  logic [0:4]    alu_PPPWW,
  input  logic [0:63]   alu_result,
  input  logic [0:63]   store_data,
  input  logic [0:31]   eff_addr,
  mem_wb_stage_if.master mem,
  output logic          wb_en,
  output logic [0:4]    wb_rD,
  output logic [0:4]    wb_PPPWW,
  output logic [0:63]   wb_data,
  output logic          stall,
  output logic          mem_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [0:31] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [0:4]    rd_q;
  logic [0:4]    pppww_q;

  // Stall depends on state only so upstream sees no combinational path.
  assign stall = (state == MEM_WAIT);

  // Stage FSM with registered bus and write-back outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_q        <= '0;
      pppww_q     <= '0;
      mem.memEn   <= 1'b0;
      mem.memWrEn <= 1'b0;
      mem.memAddr <= '0;
      mem.dataOut <= '0;
      wb_en       <= 1'b0;
      wb_rD       <= '0;
      wb_PPPWW    <= '0;
      wb_data     <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_valid) begin
            case (alu_op)
              2'b00: begin
                wb_en    <= 1'b1;
                wb_rD    <= alu_rD;
                wb_PPPWW <= alu_PPPWW;
                wb_data  <= alu_result;
              end
              2'b01, 2'b10: begin
                mem.memEn   <= 1'b1;
                mem.memWrEn <= (alu_op == 2'b10);
                mem.memAddr <= eff_addr & ADDR_MASK;
                if (alu_op == 2'b10) mem.dataOut <= store_data;
                rd_q     <= alu_rD;
                pppww_q  <= alu_PPPWW;
                wait_cnt <= '0;
                state    <= MEM_WAIT;
              end
              default: ;
            endcase
          end
        end
        MEM_WAIT: begin
          if (mem.mem_ready) begin
            // Completion has priority over a coinciding timeout.
            mem.memEn   <= 1'b0;
            mem.memWrEn <= 1'b0;
            if (!mem.memWrEn) begin
              wb_en    <= 1'b1;
              wb_rD    <= rd_q;
              wb_PPPWW <= pppww_q;
              wb_data  <= mem.dataIn;
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            mem.memEn   <= 1'b0;
            mem.memWrEn <= 1'b0;
            mem_err     <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, load/store handshakes,
// timeout, stall behaviour and synchronous reset during an access.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [0:1]  alu_op;
  logic [0:4]  alu_rD;
  logic [0:4]  alu_PPPWW;
  logic [0:63] alu_result;
  logic [0:63] store_data;
  logic [0:31] eff_addr;
  logic        wb_en;
  logic [0:4]  wb_rD;
  logic [0:4]  wb_PPPWW;
  logic [0:63] wb_data;
  logic        stall;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;
  int wb_cnt;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.ADDR_BITS(16), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_op     (alu_op),
    .alu_rD     (alu_rD),
    .alu_PPPWW  (alu_PPPWW),
    .alu_result (alu_result),
    .store_data (store_data),
    .eff_addr   (eff_addr),
    .mem        (bus),
    .wb_en      (wb_en),
    .wb_rD      (wb_rD),
    .wb_PPPWW   (wb_PPPWW),
    .wb_data    (wb_data),
    .stall      (stall),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [0:1] op, input logic [0:4] rd, input logic [0:63] res,
                       input logic [0:63] sd, input logic [0:31] addr);
    alu_valid  = 1'b1;
    alu_op     = op;
    alu_rD     = rd;
    alu_PPPWW  = 5'h12;
    alu_result = res;
    store_data = sd;
    eff_addr   = addr;
  endtask

  // Walks the MEM_WAIT phase; ready_at=0 means mem_ready is never raised.
  task automatic run_wait(input int ready_at, input logic [0:63] rdata, input bit toggle_alu,
                          output int n_cyc, output int n_wb);
    n_cyc = 0;
    n_wb  = 0;
    while (stall && n_cyc < 60) begin
      n_cyc++;
      if (ready_at != 0 && n_cyc == ready_at) begin
        bus.mem_ready = 1'b1;
        bus.dataIn    = rdata;
      end
      alu_valid  = toggle_alu ? n_cyc[0] : 1'b0;
      alu_op     = 2'b00;
      alu_rD     = 5'd9;
      alu_result = 64'h1111_2222_3333_4444;
      step();
      if (wb_en) n_wb++;
    end
    bus.mem_ready = 1'b0;
    alu_valid     = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_op = 2'b11; alu_rD = '0; alu_PPPWW = '0;
    alu_result = '0; store_data = '0; eff_addr = '0;
    bus.dataIn = '0; bus.mem_ready = 1'b0;
    step(); step();
    check("rst_wb_en",   64'(wb_en), 64'd0);
    check("rst_stall",   64'(stall), 64'd0);
    check("rst_memEn",   64'(bus.memEn), 64'd0);
    check("rst_mem_err", 64'(mem_err), 64'd0);
    reset = 1'b1;
    step();

    // back-to-back ALU results
    issue(2'b00, 5'd3, 64'h0123456789ABCDEF, '0, '0);
    step();
    check("alu1_wb_en", 64'(wb_en), 64'd1);
    check("alu1_rD",    64'(wb_rD), 64'd3);
    check("alu1_data",  64'(wb_data), 64'h0123456789ABCDEF);
    check("alu1_pppww", 64'(wb_PPPWW), 64'h12);
    issue(2'b00, 5'd4, 64'hFFFFFFFFFFFFFFFF, '0, '0);
    step();
    check("alu2_wb_en", 64'(wb_en), 64'd1);
    check("alu2_rD",    64'(wb_rD), 64'd4);
    check("alu2_data",  64'(wb_data), 64'hFFFFFFFFFFFFFFFF);
    check("alu2_stall", 64'(stall), 64'd0);
    alu_valid = 1'b0;
    step();
    check("alu_idle_wb_en", 64'(wb_en), 64'd0);
    check("alu_hold_data",  64'(wb_data), 64'hFFFFFFFFFFFFFFFF);

    // op 11 does nothing
    issue(2'b11, 5'd6, 64'h77, '0, '0);
    step();
    check("nop_wb_en", 64'(wb_en), 64'd0);
    check("nop_stall", 64'(stall), 64'd0);
    alu_valid = 1'b0;

    // load, ready on the 4th wait cycle
    issue(2'b01, 5'd7, '0, '0, 32'hDEAD0040);
    step();
    alu_valid = 1'b0;
    check("ld_memEn",   64'(bus.memEn), 64'd1);
    check("ld_memWrEn", 64'(bus.memWrEn), 64'd0);
    check("ld_memAddr", 64'(bus.memAddr), 64'h40);
    check("ld_stall",   64'(stall), 64'd1);
    run_wait(4, 64'h00000000CAFEF00D, 1'b0, cycles, wb_cnt);
    check("ld_stall_cycles", 64'(cycles), 64'd4);
    check("ld_wb_count",     64'(wb_cnt), 64'd1);
    check("ld_wb_rD",        64'(wb_rD), 64'd7);
    check("ld_wb_data",      64'(wb_data), 64'h00000000CAFEF00D);
    check("ld_memEn_off",    64'(bus.memEn), 64'd0);
    step();
    check("ld_wb_one_shot",  64'(wb_en), 64'd0);

    // store, ready in the first wait cycle
    issue(2'b10, 5'd8, '0, 64'hA5A5A5A5A5A5A5A5, 32'h00000010);
    step();
    alu_valid = 1'b0;
    check("st_memWrEn",  64'(bus.memWrEn), 64'd1);
    check("st_dataOut",  64'(bus.dataOut), 64'hA5A5A5A5A5A5A5A5);
    check("st_memAddr",  64'(bus.memAddr), 64'h10);
    run_wait(1, 64'hDEAD, 1'b0, cycles, wb_cnt);
    check("st_stall_cycles", 64'(cycles), 64'd1);
    check("st_wb_count",     64'(wb_cnt), 64'd0);
    check("st_memWrEn_off",  64'(bus.memWrEn), 64'd0);

    // ALU requests while stalled are ignored
    issue(2'b01, 5'd11, '0, '0, 32'h00000100);
    step();
    run_wait(5, 64'h5555AAAA5555AAAA, 1'b1, cycles, wb_cnt);
    check("tog_stall_cycles", 64'(cycles), 64'd5);
    check("tog_wb_count",     64'(wb_cnt), 64'd1);
    check("tog_wb_rD",        64'(wb_rD), 64'd11);
    check("tog_wb_data",      64'(wb_data), 64'h5555AAAA5555AAAA);

    // ready on the last allowed cycle wins over timeout
    issue(2'b01, 5'd12, '0, '0, 32'h00000200);
    step();
    alu_valid = 1'b0;
    run_wait(16, 64'h0BAD_F00D, 1'b0, cycles, wb_cnt);
    check("edge_cycles",  64'(cycles), 64'd16);
    check("edge_wb",      64'(wb_cnt), 64'd1);
    check("edge_mem_err", 64'(mem_err), 64'd0);

    // timeout
    issue(2'b01, 5'd2, '0, '0, 32'h00000020);
    step();
    alu_valid = 1'b0;
    run_wait(0, '0, 1'b0, cycles, wb_cnt);
    check("to_cycles",    64'(cycles), 64'd16);
    check("to_wb_count",  64'(wb_cnt), 64'd0);
    check("to_mem_err",   64'(mem_err), 64'd1);
    check("to_memEn_off", 64'(bus.memEn), 64'd0);
    issue(2'b00, 5'd5, 64'h55, '0, '0);
    step();
    alu_valid = 1'b0;
    check("post_to_wb_en",  64'(wb_en), 64'd1);
    check("post_to_data",   64'(wb_data), 64'h55);
    check("to_err_sticky",  64'(mem_err), 64'd1);

    // reset in the middle of an access
    issue(2'b01, 5'd13, '0, '0, 32'h00000300);
    step();
    alu_valid = 1'b0;
    step();
    check("mid_stall", 64'(stall), 64'd1);
    reset = 1'b0;
    step(); step();
    check("mrst_memEn",   64'(bus.memEn), 64'd0);
    check("mrst_stall",   64'(stall), 64'd0);
    check("mrst_mem_err", 64'(mem_err), 64'd0);
    check("mrst_wb_data", 64'(wb_data), 64'd0);
    check("mrst_memAddr", 64'(bus.memAddr), 64'd0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.dataIn = 64'hFFFF;
    wb_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_en) wb_cnt++;
    end
    bus.mem_ready = 1'b0;
    check("mrst_no_wb",    64'(wb_cnt), 64'd0);
    check("mrst_stall_end", 64'(stall), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
